// File: rtl/img_buf_pkg.sv
// Shared types and defaults for the image buffer arbiter.
package img_buf_pkg;

    localparam int IMG_BUF_DEPTH = 98;

    typedef enum logic {
        S_SERVE = 1'b0,
        S_CLEAR = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2,
        GNT_CLR  = 2'd3
    } gnt_t;

endpackage

// File: rtl/img_buf_rr_arbiter.sv
// Two-way round-robin arbiter: bit 0 = write, bit 1 = read, one-hot grant.
module img_buf_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Pointer only moves when both requesters compete; reset favours write.
    logic prefer_rd_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = prefer_rd_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefer_rd_q <= 1'b0;
        end else if (req == 2'b11) begin
            prefer_rd_q <= ~prefer_rd_q;
        end
    end

endmodule

// File: rtl/image_buffer_arbiter.sv
// Shares the single-port image RAM between controller writes, BNN reads and a clear sweep.
// Define IMG_BUF_RR_EN for round-robin write/read arbitration; default is write-over-read priority.
module image_buffer_arbiter
    import img_buf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = IMG_BUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_req,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_grant,
    input  logic                       rd_req,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic                       rd_grant,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    input  logic                       clear_req,
    output logic                       buffer_full,
    output logic                       buffer_empty,
    output logic                       addr_err,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    output arb_state_t                 dbg_state,
    output logic [$clog2(DEPTH+1)-1:0] dbg_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    arb_state_t        state, state_d;
    logic [CNT_W-1:0]  count, count_d;
    logic [ADDR_W-1:0] ptr, ptr_d;
    logic              full_q, empty_q;
    logic              rd_valid_q, rd_oor_q, addr_err_q;
    logic [DATA_W-1:0] rd_hold_q;
    gnt_t              gnt_sel;

    logic serve, wr_ok, wr_in, rd_in;

    assign serve = (state == S_SERVE) && !clear_req;
    assign wr_ok = wr_req && !full_q;
    assign wr_in = {1'b0, wr_addr} < DEPTH_A;
    assign rd_in = {1'b0, rd_addr} < DEPTH_A;

`ifdef IMG_BUF_RR_EN
    logic [1:0] arb_req, arb_gnt;

    assign arb_req = {serve && rd_req, serve && wr_ok};

    img_buf_rr_arbiter u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (arb_req),
        .gnt   (arb_gnt)
    );

    assign wr_grant = arb_gnt[0];
    assign rd_grant = arb_gnt[1];
`else
    assign wr_grant = serve && wr_ok;
    assign rd_grant = serve && rd_req && !wr_ok;
`endif

    always_comb begin
        gnt_sel = GNT_NONE;
        if (state == S_CLEAR) begin
            gnt_sel = GNT_CLR;
        end else if (wr_grant) begin
            gnt_sel = GNT_WR;
        end else if (rd_grant) begin
            gnt_sel = GNT_RD;
        end
    end

    // Out-of-range granted accesses never reach the RAM.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (gnt_sel)
            GNT_CLR: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = ptr;
            end
            GNT_WR: begin
                if (wr_in) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = wr_data;
                end
            end
            GNT_RD: begin
                if (rd_in) begin
                    mem_en   = 1'b1;
                    mem_addr = rd_addr;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state;
        count_d = count;
        ptr_d   = ptr;
        case (state)
            S_SERVE: begin
                if (clear_req) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end else if (wr_grant && wr_in && (count != DEPTH_C)) begin
                    count_d = count + 1'b1;
                end
            end
            S_CLEAR: begin
                if (ptr == LAST_PTR) begin
                    ptr_d   = '0;
                    count_d = '0;
                    state_d = S_SERVE;
                end else begin
                    ptr_d = ptr + 1'b1;
                end
            end
            default: state_d = S_SERVE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_SERVE;
            count      <= '0;
            ptr        <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_oor_q   <= 1'b0;
            rd_hold_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state      <= state_d;
            count      <= count_d;
            ptr        <= ptr_d;
            full_q     <= (count_d == DEPTH_C);
            empty_q    <= (count_d == '0) && (state_d == S_SERVE);
            rd_valid_q <= rd_grant;
            rd_oor_q   <= rd_grant && !rd_in;
            addr_err_q <= (wr_grant && !wr_in) || (rd_grant && !rd_in);
            if (rd_valid_q) begin
                rd_hold_q <= rd_data;
            end
        end
    end

    // RAM data lands one cycle after the grant; hold it for later cycles.
    assign rd_data      = rd_valid_q ? (rd_oor_q ? '0 : mem_rdata) : rd_hold_q;
    assign rd_valid     = rd_valid_q;
    assign addr_err     = addr_err_q;
    assign buffer_full  = full_q;
    assign buffer_empty = empty_q;
    assign dbg_state    = state;
    assign dbg_count    = count;

endmodule
